// File: rtl/dev_irq_ctrl.sv
// rtl/dev_irq_ctrl.sv - round-robin interrupt controller for N filter channels.
// Optional sticky overflow flags: define DEV_IRQ_OVF_EN to add the ovf port.
module dev_irq_ctrl #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  lvl,
  input  logic [N-1:0]  rise,
  input  logic [N-1:0]  fall,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [2:0]    cfg_wdata,
  output logic [2:0]    cfg_rdata,
  output logic          irq,
  output logic [IW-1:0] irq_id,
  input  logic          irq_ack,
  output logic [N-1:0]  pending
`ifdef DEV_IRQ_OVF_EN
  ,
  output logic [N-1:0]  ovf
`endif
);

  typedef enum logic [1:0] {IDLE, ARB, PRESENT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cfg [N];
  logic [IW-1:0] ptr;
  logic [N-1:0]  evt, cfg_hit, dis_clr, ack_clr, pend_nxt;
  logic [IW-1:0] sel;
  logic          found;
  int            scan_j;
  logic          ack_take, withdraw, arb_hit;

  // Per-channel event select, gated by the enable bit.
  always_comb begin
    evt = '0;
    for (int i = 0; i < N; i++) begin
      case (cfg[i][1:0])
        2'b00:   evt[i] = cfg[i][2] & rise[i];
        2'b01:   evt[i] = cfg[i][2] & fall[i];
        2'b10:   evt[i] = cfg[i][2] & (rise[i] | fall[i]);
        default: evt[i] = cfg[i][2] & lvl[i];
      endcase
    end
  end

  always_comb begin
    cfg_hit = '0;
    dis_clr = '0;
    ack_clr = '0;
    for (int i = 0; i < N; i++) begin
      cfg_hit[i] = cfg_we && (int'(cfg_idx) == i);
      dis_clr[i] = cfg_hit[i] && !cfg_wdata[2];
      ack_clr[i] = ack_take && (int'(irq_id) == i);
    end
  end

  // New events beat an ack clear; disabling a channel beats everything.
  assign pend_nxt = ((pending & ~ack_clr) | evt) & ~dis_clr;

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < N; i++)
      if (int'(cfg_idx) == i) cfg_rdata = cfg[i];
  end

  // First pending channel at or after ptr, wrapping at N-1.
  always_comb begin
    sel    = '0;
    found  = 1'b0;
    scan_j = 0;
    for (int k = 0; k < N; k++) begin
      scan_j = int'(ptr) + k;
      if (scan_j >= N) scan_j = scan_j - N;
      if (!found && pending[scan_j]) begin
        found = 1'b1;
        sel   = IW'(scan_j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pending) state_nxt = ARB;
      ARB:     state_nxt = arb_hit ? PRESENT : IDLE;
      PRESENT: if (ack_take || withdraw) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_take = (state == PRESENT) && irq_ack;
    withdraw = (state == PRESENT) && !irq_ack && !pend_nxt[irq_id];
    arb_hit  = (state == ARB) && found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cfg[i] <= '0;
      pending <= '0;
      ptr     <= '0;
      irq     <= 1'b0;
      irq_id  <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (cfg_hit[i]) cfg[i] <= cfg_wdata;
      pending <= pend_nxt;
      if (arb_hit) begin
        irq    <= 1'b1;
        irq_id <= sel;
      end
      if (ack_take) begin
        irq <= 1'b0;
        ptr <= (int'(irq_id) == N - 1) ? '0 : irq_id + IW'(1);
      end
      if (withdraw) irq <= 1'b0;
    end
  end

`ifdef DEV_IRQ_OVF_EN
  logic [N-1:0] ovf_set;

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < N; i++)
      ovf_set[i] = evt[i] && pending[i] && !ack_clr[i] && (cfg[i][1:0] != 2'b11);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf <= '0;
    else     ovf <= (ovf | ovf_set) & ~cfg_hit;
  end
`endif

endmodule

// File: doc/dev_irq_ctrl.md
Name: dev_irq_ctrl

Overview:
Interrupt controller for a bank of N input filter channels. Each channel's synchronized level and rise/fall pulses feed it.
- Per-channel edge/level selection and pending latching.
- Round-robin arbitration among pending channels.
- A single interrupt to the hs32 core: irq/irq_id, acknowledged by irq_ack.

Parameters:
N, 4, number of filter channels (2..16; need not be a power of two)
IW, $clog2(N), channel index width (derived; not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
lvl  in  N  synchronized channel levels
rise  in  N  one-cycle rising-edge pulses
fall  in  N  one-cycle falling-edge pulses
cfg_we  in  1  config write strobe
cfg_idx  in  IW  channel selected for config write/readback
cfg_wdata  in  3  {en, mode[1:0]}
cfg_rdata  out  3  combinational readback of cfg[cfg_idx]
irq  out  1  interrupt request to core
irq_id  out  IW  channel being presented
irq_ack  in  1  core acknowledge
pending  out  N  pending event bits

Behaviour:
- Reset: rst (synchronous, active-high, clock clk) clears cfg (all channels disabled, mode 00), pending, ptr, irq and irq_id to 0, and sets state to IDLE.
  - Reset mid-operation abandons any presented interrupt with no ack required.
- Config: cfg_we writes cfg[cfg_idx] on the clock edge.
  - A cfg_idx >= N write is ignored, and its readback is 0.
- Event select, per channel i, computed only when en=1:
  - mode 00: rise
  - mode 01: fall
  - mode 10: rise|fall
  - mode 11: lvl (level-high)
- pending[i] is set on the edge after evt[i].
  - Cleared by an accepted ack for channel i.
  - If set and clear occur in the same cycle, set wins.
  - Writing en=0 clears pending[i] on that edge.
  - In level mode, pending reasserts the cycle after ack while lvl[i] stays high.
- FSM IDLE: go to ARB when |pending.
- FSM ARB (1 cycle):
  - Select the first pending index searching from ptr upward, wrapping at N-1 to 0.
  - Latch it into irq_id, set irq=1, go to PRESENT.
  - If pending became all-zero, return to IDLE.
- FSM PRESENT: irq and irq_id are held stable.
  - On irq_ack: clear pending[irq_id], set ptr <= (irq_id==N-1) ? 0 : irq_id+1, set irq <= 0, go to IDLE.
  - If pending[irq_id] drops without ack (channel disabled): set irq <= 0, go to IDLE, leave ptr unchanged.
- irq_ack outside PRESENT is ignored.
- Latency: evt in cycle 0 → pending in cycle 1 → ARB in cycle 2 → irq=1 in cycle 3.
- After an ack, irq stays low for at least 2 cycles (IDLE, ARB).

Optional Feature:
DEV_IRQ_OVF_EN
- Defined:
  - Adds output ovf (N bits), reset 0.
  - ovf[i] is set sticky when evt[i] occurs while pending[i]=1 and pending[i] is not being cleared that cycle.
  - Level mode (11) never sets ovf.
  - Any cfg write to channel i clears ovf[i].
- Undefined: the ovf port is absent, and repeated events merge silently into pending.

Test Plan:
- Reset: rst high for 2 cycles → irq=0, irq_id=0, pending=0000, cfg_rdata=000 for all idx; rise pulses ignored because all channels are disabled.
- Single edge: N=4, cfg ch2=100 (en, rise); rise[2] pulse in cycle 0 → pending=0100 in cycle 1, irq=1 with irq_id=2 in cycle 3; irq_ack → next cycle irq=0, pending=0000, ptr=3.
- Round-robin: ch0, ch1 and ch3 enabled in rise mode, pulsed together with ptr=0 → served in order 0, 1, 3, each after ack. Then pend ch0 and ch3 with ptr=2 → ch3 is served first, then ch0 (wrap).
- Mode select: ch1 mode 00, fall[1] pulse → no pending. Mode 01 → pending. Mode 10 with rise then fall → two interrupts, each acked.
- Level mode and withdraw: ch0 mode 11, lvl[0] high; ack → pending reasserts next cycle, irq again. Write ch0 en=0 while in PRESENT → irq=0 next cycle, pending[0]=0, no ack needed.
- Simultaneous events: rise[2] in the same cycle as the ack for ch2 → pending[2] stays 1 and irq is reissued with id=2. With DEV_IRQ_OVF_EN, a second rise[2] before ack → ovf[2]=1; a cfg write to ch2 → ovf[2]=0.
